// File: rtl/alu_pkg.sv
// Shared encodings for the ID/EX stage: ALU operation codes, ALUOp classes,
// forwarding selects and the shift-amount width.
package alu_pkg;

    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SRA = 4'b0111,
        ALU_EQ  = 4'b1000,
        ALU_SLT = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {
        ALUOP_MEM    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_ARITH  = 2'b10,
        ALUOP_UPPER  = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10,
        FWD_REG2 = 2'b11
    } fwd_sel_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUOp/Funct3/Funct7b5/IsRType to ALU operation decode.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       is_rtype,
    output logic [3:0] operation
);

    alu_op_t op;

    always_comb begin
        op = ALU_ADD;
        case (aluop_t'(alu_op))
            ALUOP_BRANCH: begin
                // BNE shares EQ; the branch unit inverts the result
                case (funct3)
                    3'b000, 3'b001: op = ALU_EQ;
                    3'b100, 3'b101: op = ALU_SLT;
                    default:        op = ALU_SUB;
                endcase
            end
            ALUOP_ARITH: begin
                case (funct3)
                    3'b000:  op = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLT;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            default: op = ALU_ADD;
        endcase
    end

    assign operation = op;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: one-slot valid/ready stage with
// operation decode, EX forwarding and ALUSrc mux. Optional macro: EX_FORWARD_EN.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    rs1_data,
    input  logic [DATA_WIDTH-1:0]    rs2_data,
    input  logic [DATA_WIDTH-1:0]    imm,
    input  logic [DATA_WIDTH-1:0]    pc,
    input  logic [REG_ADDR_W-1:0]    rd,
    input  logic                     ALUSrc,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic                     Funct7b5,
    input  logic                     IsRType,
    input  logic                     RegWrite,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic                     Branch,
    input  logic                     flush,
    input  logic [1:0]               fwd_a_sel,
    input  logic [1:0]               fwd_b_sel,
    input  logic [DATA_WIDTH-1:0]    mem_result,
    input  logic [DATA_WIDTH-1:0]    wb_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    store_data,
    output logic [DATA_WIDTH-1:0]    pc_q,
    output logic [REG_ADDR_W-1:0]    rd_q,
    output logic                     RegWrite_q,
    output logic                     MemRead_q,
    output logic                     MemWrite_q,
    output logic                     Branch_q
);

    localparam int NCTRL = 4;

    logic                     valid_reg;
    logic [DATA_WIDTH-1:0]    rs1_reg, rs2_reg, imm_reg, pc_reg;
    logic [REG_ADDR_W-1:0]    rd_reg;
    logic                     alusrc_reg;
    logic [OPCODE_LENGTH-1:0] op_reg;
    logic [NCTRL-1:0]         ctrl_reg;
    logic [NCTRL-1:0]         ctrl_in;
    logic [NCTRL-1:0]         ctrl_out;
    logic [3:0]               dec_op;
    logic                     load;

    alu_decoder u_dec (
        .alu_op   (ALUOp),
        .funct3   (Funct3),
        .funct7b5 (Funct7b5),
        .is_rtype (IsRType),
        .operation(dec_op)
    );

    assign in_ready = !valid_reg || out_ready;
    assign load     = in_valid && in_ready;
    assign ctrl_in  = {Branch, MemWrite, MemRead, RegWrite};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg  <= 1'b0;
            rs1_reg    <= '0;
            rs2_reg    <= '0;
            imm_reg    <= '0;
            pc_reg     <= '0;
            rd_reg     <= '0;
            alusrc_reg <= 1'b0;
            op_reg     <= '0;
            ctrl_reg   <= '0;
        end else if (flush) begin
            // data fields hold; they are don't-care while the slot is empty
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
        end else if (load) begin
            valid_reg  <= 1'b1;
            rs1_reg    <= rs1_data;
            rs2_reg    <= rs2_data;
            imm_reg    <= imm;
            pc_reg     <= pc;
            rd_reg     <= rd;
            alusrc_reg <= ALUSrc;
            op_reg     <= OPCODE_LENGTH'(dec_op);
            ctrl_reg   <= ctrl_in;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < NCTRL; gi++) begin : g_ctrl_q
            assign ctrl_out[gi] = ctrl_reg[gi] & valid_reg;
        end
    endgenerate

    assign {Branch_q, MemWrite_q, MemRead_q, RegWrite_q} = ctrl_out;
    assign out_valid = valid_reg;
    assign Operation = op_reg;
    assign pc_q      = pc_reg;
    assign rd_q      = rd_reg;

`ifdef EX_FORWARD_EN
    always_comb begin
        case (fwd_sel_t'(fwd_a_sel))
            FWD_MEM: SrcA = mem_result;
            FWD_WB:  SrcA = wb_result;
            default: SrcA = rs1_reg;
        endcase
    end

    always_comb begin
        case (fwd_sel_t'(fwd_b_sel))
            FWD_MEM: store_data = mem_result;
            FWD_WB:  store_data = wb_result;
            default: store_data = rs2_reg;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_a_sel, fwd_b_sel, mem_result, wb_result};
    assign SrcA       = rs1_reg;
    assign store_data = rs2_reg;
`endif

    logic [DATA_WIDTH-1:0] srcb_raw;
    assign srcb_raw = alusrc_reg ? imm_reg : store_data;

    // shifts use only shamt so SRAI's imm bit 10 never reaches the shifter
    assign SrcB = is_shift(op_reg[3:0]) ? DATA_WIDTH'(srcb_raw[SHAMT_W-1:0]) : srcb_raw;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage; forwarding expectations follow EX_FORWARD_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic [4:0]  rd;
    logic        ALUSrc;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic        Funct7b5, IsRType;
    logic        RegWrite, MemRead, MemWrite, Branch;
    logic        flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [31:0] mem_result, wb_result;
    logic        out_valid, out_ready;
    logic [31:0] SrcA, SrcB, store_data, pc_q;
    logic [3:0]  Operation;
    logic [4:0]  rd_q;
    logic        RegWrite_q, MemRead_q, MemWrite_q, Branch_q;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc), .rd(rd),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Funct3(Funct3), .Funct7b5(Funct7b5),
        .IsRType(IsRType), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .Branch(Branch), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_result(mem_result), .wb_result(wb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .store_data(store_data),
        .pc_q(pc_q), .rd_q(rd_q), .RegWrite_q(RegWrite_q), .MemRead_q(MemRead_q),
        .MemWrite_q(MemWrite_q), .Branch_q(Branch_q)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
            $display("check %-16s obs=0x%08h exp=0x%08h ok", tag, obs, exp);
        end else begin
            $display("FAIL %-16s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one beat at the falling edge; caller decides when to clock it.
    task automatic present(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                           input logic isr, input logic asrc, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] im,
                           input logic [4:0] d, input logic rw);
        @(negedge clk);
        in_valid = 1'b1; ALUOp = aop; Funct3 = f3; Funct7b5 = f7; IsRType = isr;
        ALUSrc = asrc; rs1_data = r1; rs2_data = r2; imm = im; rd = d; RegWrite = rw;
        pc = r1 + 32'h100;
    endtask

    task automatic clock_beat();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        rs1_data = 32'h55; rs2_data = 32'h66; imm = 0; pc = 0; rd = 5'd9;
        ALUSrc = 0; ALUOp = 2'b10; Funct3 = 3'b100; Funct7b5 = 0; IsRType = 1;
        RegWrite = 1; MemRead = 0; MemWrite = 0; Branch = 0;
        fwd_a_sel = 2'b00; fwd_b_sel = 2'b00; mem_result = 0; wb_result = 0;

        // reset with in_valid high must stay empty
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_operation", 32'(Operation), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_rd_q", 32'(rd_q), 0);
        check("rst_regwrite_q", 32'(RegWrite_q), 0);
        in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // R-type SUB
        present(2'b10, 3'b000, 1, 1, 0, 32'd10, 32'd3, 32'd0, 5'd4, 1);
        check("pre_out_valid", 32'(out_valid), 0);
        clock_beat();
        check("sub_valid", 32'(out_valid), 1);
        check("sub_op", 32'(Operation), 32'h1);
        check("sub_srca", SrcA, 32'd10);
        check("sub_srcb", SrcB, 32'd3);
        check("sub_rd_q", 32'(rd_q), 4);
        check("sub_pc_q", pc_q, 32'h10a);
        check("sub_rw_q", 32'(RegWrite_q), 1);
        @(posedge clk); #1;
        check("drain_valid", 32'(out_valid), 0);
        check("drain_rw_q", 32'(RegWrite_q), 0);

        // SRAI: shamt only
        present(2'b10, 3'b101, 1, 0, 1, 32'h8000_0000, 32'd0, 32'h404, 5'd5, 1);
        clock_beat();
        check("srai_op", 32'(Operation), 32'h7);
        check("srai_srcb", SrcB, 32'd4);
        // ADDI with Funct7b5 set stays ADD
        present(2'b10, 3'b000, 1, 0, 1, 32'd1, 32'd0, 32'h420, 5'd6, 1);
        clock_beat();
        check("addi_op", 32'(Operation), 32'h2);
        check("addi_srcb", SrcB, 32'h420);
        // SRL register shift masks rs2
        present(2'b10, 3'b101, 0, 1, 0, 32'd1, 32'h25, 32'd0, 5'd7, 1);
        clock_beat();
        check("srl_op", 32'(Operation), 32'h6);
        check("srl_srcb", SrcB, 32'd5);
        // BLT / BNE / BGEU-style / load
        present(2'b01, 3'b100, 0, 0, 0, 32'd1, 32'd2, 32'd0, 5'd0, 0);
        clock_beat();
        check("blt_op", 32'(Operation), 32'h9);
        present(2'b01, 3'b001, 0, 0, 0, 32'd1, 32'd2, 32'd0, 5'd0, 0);
        clock_beat();
        check("bne_op", 32'(Operation), 32'h8);
        present(2'b01, 3'b110, 0, 0, 0, 32'd1, 32'd2, 32'd0, 5'd0, 0);
        clock_beat();
        check("bltu_op", 32'(Operation), 32'h1);
        present(2'b00, 3'b010, 1, 0, 1, 32'd1, 32'd2, 32'd8, 5'd3, 1);
        clock_beat();
        check("load_op", 32'(Operation), 32'h2);
        present(2'b10, 3'b110, 0, 1, 0, 32'd1, 32'd2, 32'd0, 5'd3, 1);
        clock_beat();
        check("or_op", 32'(Operation), 32'h3);

        // back-to-back: no bubble
        present(2'b10, 3'b100, 0, 1, 0, 32'hA1, 32'd2, 32'd0, 5'd10, 1);
        @(posedge clk); #1;
        check("b2b_a_srca", SrcA, 32'hA1);
        present(2'b10, 3'b111, 0, 1, 0, 32'hB2, 32'd2, 32'd0, 5'd11, 1);
        @(posedge clk); #1;
        check("b2b_b_valid", 32'(out_valid), 1);
        check("b2b_b_srca", SrcA, 32'hB2);
        check("b2b_b_op", 32'(Operation), 32'h0);
        in_valid = 1'b0;

        // stall three cycles with a competing input
        present(2'b10, 3'b100, 0, 1, 0, 32'h77, 32'h88, 32'd0, 5'd12, 1);
        clock_beat();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; rs1_data = 32'h99; rd = 5'd13;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_srca", SrcA, 32'h77);
            check("stall_rd_q", 32'(rd_q), 12);
        end

        // forwarding while stalled
        fwd_a_sel = 2'b01; mem_result = 32'hDEAD;
        fwd_b_sel = 2'b10; wb_result = 32'd7;
        #1;
`ifdef EX_FORWARD_EN
        check("fwd_srca", SrcA, 32'hDEAD);
        check("fwd_srcb", SrcB, 32'd7);
        check("fwd_store", store_data, 32'd7);
`else
        check("nofwd_srca", SrcA, 32'h77);
        check("nofwd_srcb", SrcB, 32'h88);
        check("nofwd_store", store_data, 32'h88);
`endif
        fwd_a_sel = 2'b11; fwd_b_sel = 2'b00;
        #1;
        check("fwd11_srca", SrcA, 32'h77);

        // flush while stalled with in_valid high
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        check("flush_valid", 32'(out_valid), 0);
        check("flush_rw_q", 32'(RegWrite_q), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        // flush on empty slot discards the accepted beat
        @(posedge clk); #1;
        check("flush2_valid", 32'(out_valid), 0);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;

        // async reset mid-stall
        present(2'b10, 3'b100, 0, 1, 0, 32'h44, 32'd0, 32'd0, 5'd14, 1);
        clock_beat();
        check("pre_rst_valid", 32'(out_valid), 1);
        #2; rst_n = 1'b0; #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_rd_q", 32'(rd_q), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_valid", 32'(out_valid), 0);
        check("post_rst_in_rdy", 32'(in_ready), 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
